// File: rtl/tl_phase_sched.sv
// tl_phase_sched: four-approach traffic light phase scheduler.
// One approach is active at a time. It cycles GREEN -> YELLOW -> ALLRED and
// then hands over round-robin to the next waiting approach. Green is extended
// while the active approach keeps detecting vehicles, and an emergency request
// can preempt the round-robin order.
module tl_phase_sched #(
    parameter logic [15:0] G_MIN   = 16'd49,
    parameter logic [15:0] G_MAX   = 16'd299,
    parameter logic [15:0] Y_SCALE = 16'd29,
    parameter logic [15:0] R_SCALE = 16'd29
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       tick,
    input  logic [3:0] sensor,
    input  logic       emg_req,
    input  logic [1:0] emg_idx,
    output logic [2:0] tl_signal,
    output logic [1:0] index,
    output logic [3:0] pending,
    output logic       phase_start,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [1:0]  pick;
    logic [1:0]  index_nx;
    logic [3:0]  pend_nx;
    logic [3:0]  green_mask;
    logic [2:0]  sig_nx;
    logic        others;
    logic        own_emg;
    logic        foreign_emg;
    logic        green_done;
    logic        enter_green;

    assign fsm_state   = state;
    assign green_mask  = (state == S_GREEN) ? (4'b0001 << index) : 4'b0000;
    assign others      = |(pending & ~(4'b0001 << index));
    assign own_emg     = emg_req && (emg_idx == index);
    assign foreign_emg = emg_req && (emg_idx != index);
    // Minimum green served; leave once the active sensor drops or the maximum is hit.
    assign green_done  = tick && (cnt >= G_MIN) && (!sensor[index] || (cnt >= G_MAX));

    // Next approach: nearest pending bit after the current one, current one last; emergency overrides.
    always_comb begin
        pick = index;
        for (int k = 4; k >= 1; k--) begin
            if (pending[index + 2'(k)]) pick = index + 2'(k);
        end
        if (emg_req) pick = emg_idx;
    end

    // Phase transitions.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if ((|pending) || emg_req) state_nx = S_GREEN;
            end
            S_GREEN: begin
                if (foreign_emg) state_nx = S_YELLOW;
                else if (others && !own_emg && green_done) state_nx = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && (cnt == Y_SCALE)) state_nx = S_ALLRED;
            end
            default: begin
                if (tick && (cnt == R_SCALE))
                    state_nx = ((|pending) || emg_req) ? S_GREEN : S_IDLE;
            end
        endcase
    end

    // Counter, index, request latch and light encoding for the next cycle.
    always_comb begin
        enter_green = (state_nx == S_GREEN) && (state != S_GREEN);
        index_nx    = enter_green ? pick : index;

        cnt_nx = cnt;
        if (state_nx != state) begin
            cnt_nx = 16'd0;
        end else if (tick) begin
            // A resting green parks at G_MIN so a new request expires it on the next tick.
            if ((state == S_GREEN) && (!others || own_emg) && (cnt >= G_MIN)) cnt_nx = cnt;
            else cnt_nx = cnt + 16'd1;
        end

        pend_nx = pending | (sensor & ~green_mask);
        if (enter_green) pend_nx[pick] = 1'b0;

        case (state_nx)
            S_GREEN:  sig_nx = 3'b001;
            S_YELLOW: sig_nx = 3'b010;
            default:  sig_nx = 3'b100;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            index       <= 2'd0;
            pending     <= 4'b0000;
            phase_start <= 1'b0;
            tl_signal   <= 3'b100;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            index       <= index_nx;
            pending     <= pend_nx;
            phase_start <= enter_green;
            tl_signal   <= sig_nx;
        end
    end

endmodule
